// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode, immediate
// extension, load-use hazard detection and bubble insertion.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [5:0]  id_funct,
    input  logic [1:0]  id_alu_op,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [2:0]  alu_ctr,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_wreg,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_valid,
    output logic        hazard
);

    // Registered EX state
    logic [31:0] rs_data_q, rt_data_q, imm_q;
    logic [2:0]  alu_ctr_q;
    logic [4:0]  wreg_q, rs_q, rt_q;
    logic        alu_src_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, valid_q;

    // Decoded ID values to load when no bubble/hold applies
    logic [2:0]  alu_ctr_d;
    logic [31:0] imm_d;

    // ALU control decode from alu_op and funct
    always_comb begin
        alu_ctr_d = 3'b000;
        case (id_alu_op)
            2'b00: alu_ctr_d = 3'b000;
            2'b01: alu_ctr_d = 3'b001;
            2'b11: alu_ctr_d = 3'b010;
            default: begin
                case (id_funct)
                    6'b100000: alu_ctr_d = 3'b000;
                    6'b100010: alu_ctr_d = 3'b001;
                    6'b100101: alu_ctr_d = 3'b010;
                    6'b100100: alu_ctr_d = 3'b011;
                    6'b011000: alu_ctr_d = 3'b100;
                    default:   alu_ctr_d = 3'b000;
                endcase
            end
        endcase
    end

    // ori takes a zero-extended immediate; everything else sign-extends
    always_comb begin
        imm_d = (id_alu_op == 2'b11) ? {16'h0000, id_imm} : {{16{id_imm[15]}}, id_imm};
    end

    // Load-use: a load in EX whose target is read by the instruction in ID
    always_comb begin
        hazard = valid_q & mem_read_q & (rt_q != 5'd0) & id_valid &
                 ((rt_q == id_rs) | (rt_q == id_rt));
    end

    // Pipeline register: reset > flush bubble > stall hold > hazard bubble > load
    always_ff @(posedge clk or posedge rst) begin
        if (rst || (!stall && flush) || (stall && flush)) begin
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            alu_ctr_q    <= '0;
            wreg_q       <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            valid_q      <= 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (hazard) begin
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            alu_ctr_q    <= '0;
            wreg_q       <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            imm_q        <= imm_d;
            alu_ctr_q    <= alu_ctr_d;
            wreg_q       <= id_reg_dst ? id_rd : id_rt;
            rs_q         <= id_rs;
            rt_q         <= id_rt;
            alu_src_q    <= id_alu_src;
            reg_write_q  <= id_reg_write;
            mem_read_q   <= id_mem_read;
            mem_write_q  <= id_mem_write;
            mem_to_reg_q <= id_mem_to_reg;
            valid_q      <= id_valid;
        end
    end

    // Outputs straight from registered state; operand-2 mux adds no cycle
    always_comb begin
        alu_data1     = rs_data_q;
        alu_data2     = alu_src_q ? imm_q : rt_data_q;
        alu_ctr       = alu_ctr_q;
        ex_store_data = rt_data_q;
        ex_wreg       = wreg_q;
        ex_rs         = rs_q;
        ex_rt         = rt_q;
        ex_reg_write  = reg_write_q;
        ex_mem_read   = mem_read_q;
        ex_mem_write  = mem_write_q;
        ex_mem_to_reg = mem_to_reg_q;
        ex_valid      = valid_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [31:0] alu_data1, alu_data2, ex_store_data;
    logic [2:0]  alu_ctr;
    logic [4:0]  ex_wreg, ex_rs, ex_rt;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid, hazard;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctr(alu_ctr),
        .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_valid(ex_valid), .hazard(hazard)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // one rising edge, then settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive a blank, invalid ID slot
    task automatic id_idle();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_funct = 0; id_alu_op = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        id_idle();
        #3;
        chk("rst_valid", ex_valid, 0);
        chk("rst_data1", alu_data1, 0);
        chk("rst_hazard", hazard, 0);
        step();
        rst = 0;

        // R-type sub
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100010;
        id_rs_data = 9; id_rt_data = 4; id_alu_src = 0; id_reg_dst = 1;
        id_rd = 7; id_rt = 3; id_rs = 2; id_reg_write = 1;
        step();
        chk("sub_ctr", alu_ctr, 3'b001);
        chk("sub_d1", alu_data1, 9);
        chk("sub_d2", alu_data2, 4);
        chk("sub_wreg", ex_wreg, 7);
        chk("sub_valid", ex_valid, 1);

        // sign-extended immediate, then zero-extended for ori
        id_alu_op = 2'b00; id_alu_src = 1; id_imm = 16'hFFF0; id_reg_dst = 0;
        step();
        chk("sext_d2", alu_data2, 32'hFFFF_FFF0);
        chk("sext_ctr", alu_ctr, 3'b000);
        chk("sext_wreg", ex_wreg, 3);
        id_alu_op = 2'b11;
        step();
        chk("zext_d2", alu_data2, 32'h0000_FFF0);
        chk("zext_ctr", alu_ctr, 3'b010);

        // mul then unknown funct
        id_alu_op = 2'b10; id_alu_src = 0; id_funct = 6'b011000;
        step();
        chk("mul_ctr", alu_ctr, 3'b100);
        id_funct = 6'b101010;
        step();
        chk("unk_ctr", alu_ctr, 3'b000);
        id_funct = 6'b100100;
        step();
        chk("and_ctr", alu_ctr, 3'b011);

        // load-use: lw to r5, then dependent add; stall first holds the load
        id_idle();
        id_valid = 1; id_rt = 5; id_rs = 1; id_mem_read = 1; id_mem_to_reg = 1;
        id_reg_write = 1; id_alu_src = 1; id_imm = 16'h0004;
        step();
        id_idle();
        id_valid = 1; id_rs = 5; id_rt = 2; id_rd = 6; id_reg_dst = 1;
        id_alu_op = 2'b10; id_funct = 6'b100000; id_reg_write = 1;
        id_rs_data = 32'h11; id_rt_data = 32'h22;
        #1;
        chk("lu_hazard", hazard, 1);
        stall = 1;
        step();
        chk("lu_stall_mread", ex_mem_read, 1);
        chk("lu_stall_hazard", hazard, 1);
        stall = 0;
        step();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_rw", ex_reg_write, 0);
        chk("lu_bub_hazard", hazard, 0);
        step();
        chk("lu_dep_valid", ex_valid, 1);
        chk("lu_dep_rs", ex_rs, 5);
        chk("lu_dep_wreg", ex_wreg, 6);

        // load to r0 never raises hazard
        id_idle();
        id_valid = 1; id_rt = 0; id_mem_read = 1;
        step();
        id_idle();
        id_valid = 1; id_rs = 0; id_rt = 0;
        #1;
        chk("r0_hazard", hazard, 0);

        // add in EX, stall 3 cycles, then flush with stall
        id_idle();
        id_valid = 1; id_rs_data = 3; id_rt_data = 4; id_rt = 8; id_rs = 9;
        id_reg_write = 1;
        step();
        id_rs_data = 32'hAA; id_rt_data = 32'hBB; id_rt = 10;
        stall = 1;
        for (int i = 0; i < 3; i++) step();
        chk("stall_d1", alu_data1, 3);
        chk("stall_d2", alu_data2, 4);
        chk("stall_rt", ex_rt, 8);
        chk("stall_valid", ex_valid, 1);
        flush = 1;
        step();
        chk("flush_valid", ex_valid, 0);
        chk("flush_d1", alu_data1, 0);
        chk("flush_rw", ex_reg_write, 0);
        chk("flush_rt", ex_rt, 0);
        stall = 0; flush = 0;

        // sw in EX, then asynchronous reset between edges
        id_idle();
        id_valid = 1; id_mem_write = 1; id_rt_data = 32'hDEAD; id_rs_data = 32'h40;
        id_alu_src = 1; id_imm = 16'h0008; id_alu_op = 2'b01;
        step();
        chk("sw_mwrite", ex_mem_write, 1);
        chk("sw_store", ex_store_data, 32'hDEAD);
        #1 rst = 1;
        #1;
        chk("arst_mwrite", ex_mem_write, 0);
        chk("arst_store", ex_store_data, 0);
        chk("arst_d2", alu_data2, 0);
        chk("arst_ctr", alu_ctr, 0);
        chk("arst_valid", ex_valid, 0);
        #1 rst = 0;
        step();
        chk("post_rst_valid", ex_valid, 1);
        chk("post_rst_d2", alu_data2, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
